// File: rtl/nios_system_ram_arbiter_if.sv
// nios_system_ram_arbiter_if: one requester port of the RAM arbiter.
// The master modport is the requester side, the slave modport is the arbiter side.

interface nios_system_ram_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              lock;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_system_ram_arbiter.sv
// nios_system_ram_arbiter: two requesters share one single-port RAM (port s1).
// Grants are decided combinationally with round-robin on contention, accesses are
// accepted in the cycle they are granted, and read data returns one cycle later.
// Optional feature: define NIOS_SYSTEM_RAM_ARB_LOCK_EN to let the last granted
// requester keep the RAM while it asserts lock, bounded to 8 consecutive grants.

module nios_system_ram_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    nios_system_ram_arbiter_if.slave  m0,
    nios_system_ram_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]         ram_address,
    output logic [BE_W-1:0]           ram_byteenable,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [DATA_W-1:0]         ram_writedata,
    input  logic [DATA_W-1:0]         ram_readdata
);

    logic req0;
    logic req1;
    logic grant0;
    logic grant1;

    logic last_grant_q;
    logic last_grant_d;
    logic rd_pending_q;
    logic rd_pending_d;
    logic rd_owner_q;
    logic rd_owner_d;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
    logic [2:0] lock_cnt_q;
    logic [2:0] lock_cnt_d;
    logic       hold0;
    logic       hold1;

    // A lock only counts for the requester that owned the last grant, and a
    // count of 7 means the owner already had 8 grants in a row, so it yields once.
    assign hold0 = ~last_grant_q & m0.lock & req0 & (lock_cnt_q != 3'd7);
    assign hold1 =  last_grant_q & m1.lock & req1 & (lock_cnt_q != 3'd7);
`else
    logic unused_lock;
    assign unused_lock = m0.lock | m1.lock;
`endif

    // Pick at most one winner this cycle; reset suppresses every grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req0 && req1) begin
`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
                if (hold0) begin
                    grant0 = 1'b1;
                end else if (hold1) begin
                    grant1 = 1'b1;
                end else if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
`else
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
`endif
            end else if (req0) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
    end

    // Steer the granted requester onto the RAM port; an idle port drives all zeros.
    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (grant0) begin
            ram_chipselect = 1'b1;
            ram_write      = m0.write;
            ram_address    = m0.address;
            ram_byteenable = m0.byteenable;
            ram_writedata  = m0.writedata;
        end else if (grant1) begin
            ram_chipselect = 1'b1;
            ram_write      = m1.write;
            ram_address    = m1.address;
            ram_byteenable = m1.byteenable;
            ram_writedata  = m1.writedata;
        end
    end

    // Next arbitration history and read-return bookkeeping.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
        rd_pending_d = (grant0 | grant1) & ~ram_write;
        rd_owner_d   = rd_pending_d ? grant1 : rd_owner_q;
    end

`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
    // Count consecutive locked grants to the same owner; anything else restarts it.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (grant0) begin
            lock_cnt_d = hold0 ? lock_cnt_q + 3'd1 : 3'd0;
        end else if (grant1) begin
            lock_cnt_d = hold1 ? lock_cnt_q + 3'd1 : 3'd0;
        end
    end

    // Lock counter register; reset starts with no lock history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt_q <= 3'd0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    // Arbitration and read state; reset makes m0 win the first tie and drops any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign m0.waitrequest   = req0 & ~grant0;
    assign m1.waitrequest   = req1 & ~grant1;

    assign m0.readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_pending_q &  rd_owner_q;
    assign m0.readdata      = (rd_pending_q & ~rd_owner_q) ? ram_readdata : '0;
    assign m1.readdata      = (rd_pending_q &  rd_owner_q) ? ram_readdata : '0;

endmodule

// File: tb/tb_nios_system_ram_arbiter.sv
// tb_nios_system_ram_arbiter: randomized and directed checks of the RAM arbiter
// against a cycle-level reference model of the grant rules and a RAM image.
// Define NIOS_SYSTEM_RAM_ARB_LOCK_EN to also exercise the lock feature.

module tb_nios_system_ram_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int VW = 2 + 1 + 1 + AW + BW + DW + 2 + 2 * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    logic          drv_rd   [2];
    logic          drv_wr   [2];
    logic          drv_lock [2];
    logic [AW-1:0] drv_addr [2];
    logic [BW-1:0] drv_be   [2];
    logic [DW-1:0] drv_wd   [2];

    nios_system_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0_if ();
    nios_system_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1_if ();

    assign m0_if.read       = drv_rd[0];
    assign m0_if.write      = drv_wr[0];
    assign m0_if.lock       = drv_lock[0];
    assign m0_if.address    = drv_addr[0];
    assign m0_if.byteenable = drv_be[0];
    assign m0_if.writedata  = drv_wd[0];
    assign m1_if.read       = drv_rd[1];
    assign m1_if.write      = drv_wr[1];
    assign m1_if.lock       = drv_lock[1];
    assign m1_if.address    = drv_addr[1];
    assign m1_if.byteenable = drv_be[1];
    assign m1_if.writedata  = drv_wd[1];

    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic          ram_chipselect;
    logic          ram_write;
    logic [DW-1:0] ram_writedata;
    logic [DW-1:0] ram_readdata;

    nios_system_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_readdata   (ram_readdata)
    );

    // Single-port RAM with one cycle of read latency and byte-lane writes.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_word(input int i);
        logic [7:0] lo;
        lo = 8'(i);
        return {8'hA5, lo, 8'h3C, ~lo};
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= init_word(i);
    end

    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end
            ram_readdata <= ram_mem[ram_address];
        end
    end

    // Reference model state.
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    int            mdl_last;
    bit            mdl_rsp_v;
    int            mdl_rsp_own;
    logic [DW-1:0] mdl_rsp_d;
    int            mdl_streak;
    int            exp_grant;
    logic [VW-1:0] exp_vec;
    logic [VW-1:0] obs_vec;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        mdl_last   = 1;
        mdl_rsp_v  = 1'b0;
        mdl_rsp_own = 0;
        mdl_rsp_d  = '0;
        mdl_streak = 0;
    endtask

    task automatic set_req(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd, input logic lk);
        drv_rd[m]   = rd;
        drv_wr[m]   = wr;
        drv_addr[m] = a;
        drv_be[m]   = be;
        drv_wd[m]   = wd;
        drv_lock[m] = lk;
    endtask

    task automatic idle_all();
        set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Settle after the inputs change, then form expected and observed port images.
    task automatic eval_cycle();
        int            g;
        bit            r0;
        bit            r1;
        logic [1:0]    e_wait;
        logic [1:0]    e_rdv;
        logic          e_cs;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [BW-1:0] e_be;
        logic [DW-1:0] e_wd;
        logic [DW-1:0] e_rd0;
        logic [DW-1:0] e_rd1;
        #1;
        r0 = drv_rd[0] | drv_wr[0];
        r1 = drv_rd[1] | drv_wr[1];
        g = -1;
        if (reset_n) begin
            if (r0 && r1) begin
                g = 1 - mdl_last;
`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
                if (drv_lock[mdl_last] && mdl_streak < 7) g = mdl_last;
`endif
            end else if (r0) begin
                g = 0;
            end else if (r1) begin
                g = 1;
            end
        end
        exp_grant = g;
        e_cs = 1'b0; e_we = 1'b0; e_a = '0; e_be = '0; e_wd = '0;
        if (g >= 0) begin
            e_cs = 1'b1;
            e_we = drv_wr[g];
            e_a  = drv_addr[g];
            e_be = drv_be[g];
            e_wd = drv_wd[g];
        end
        e_wait = {r1 && g != 1, r0 && g != 0};
        e_rdv  = {mdl_rsp_v && mdl_rsp_own == 1, mdl_rsp_v && mdl_rsp_own == 0};
        e_rd1  = e_rdv[1] ? mdl_rsp_d : '0;
        e_rd0  = e_rdv[0] ? mdl_rsp_d : '0;
        exp_vec = {e_wait, e_cs, e_we, e_a, e_be, e_wd, e_rdv, e_rd1, e_rd0};
        obs_vec = {m1_if.waitrequest, m0_if.waitrequest, ram_chipselect, ram_write, ram_address,
                   ram_byteenable, ram_writedata, m1_if.readdatavalid, m0_if.readdatavalid,
                   m1_if.readdata, m0_if.readdata};
    endtask

    // Apply this cycle's accepted access to the model and move to the next falling edge.
    task automatic commit_cycle();
        int g;
        g = exp_grant;
        if (reset_n && g >= 0) begin
            if (drv_wr[g]) begin
                for (int b = 0; b < BW; b++)
                    if (drv_be[g][b]) mdl_mem[drv_addr[g]][8*b +: 8] = drv_wd[g][8*b +: 8];
                mdl_rsp_v = 1'b0;
            end else begin
                mdl_rsp_v   = 1'b1;
                mdl_rsp_own = g;
                mdl_rsp_d   = mdl_mem[drv_addr[g]];
            end
            if (g == mdl_last && drv_lock[g] && mdl_streak < 7) mdl_streak = mdl_streak + 1;
            else mdl_streak = 0;
            mdl_last = g;
        end else begin
            mdl_rsp_v = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle_all();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        reset_n = 1'b0;
        model_reset();
        set_req(0, 1'b1, 1'b0, 7'h03, 4'hF, '0, 1'b0);
        set_req(1, 1'b0, 1'b1, 7'h04, 4'hF, 32'h1234_5678, 1'b0);
        for (int k = 0; k < 2; k++) begin
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL reset_hold cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            n_cmp++;
            if (ram_chipselect !== 1'b0 || {m1_if.waitrequest, m0_if.waitrequest} !== 2'b11) begin
                n_bad++;
                $display("[TB] FAIL reset_no_grant: got cs=%b wait=%b%b expected cs=0 wait=11",
                         ram_chipselect, m1_if.waitrequest, m0_if.waitrequest);
            end
            commit_cycle();
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) idle_all();
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL reset_release cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            commit_cycle();
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            idle_all();
            if (k == 0) set_req(0, 1'b0, 1'b1, 7'h05, 4'hF, 32'hDEAD_BEEF, 1'b0);
            if (k == 1) set_req(0, 1'b1, 1'b0, 7'h05, 4'hF, '0, 1'b0);
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL write_read cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (k < 2) begin
                n_cmp++;
                if (m0_if.waitrequest !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL write_read_wait cyc%0d: got %b expected 0", k, m0_if.waitrequest);
                end
            end else begin
                n_cmp++;
                if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hDEAD_BEEF) begin
                    n_bad++;
                    $display("[TB] FAIL write_read_data: got v=%b d=%h expected v=1 d=deadbeef",
                             m0_if.readdatavalid, m0_if.readdata);
                end
            end
            commit_cycle();
        end
    endtask

    task automatic test_contention();
        logic [1:0] want_wait;
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            idle_all();
            if (k < 6) begin
                set_req(0, 1'b1, 1'b0, 7'h10, 4'hF, '0, 1'b0);
                set_req(1, 1'b1, 1'b0, 7'h11, 4'hF, '0, 1'b0);
            end
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL contention cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (k < 6) begin
                want_wait = (k % 2 == 0) ? 2'b10 : 2'b01;
                n_cmp++;
                if ({m1_if.waitrequest, m0_if.waitrequest} !== want_wait) begin
                    n_bad++;
                    $display("[TB] FAIL contention_order cyc%0d: got %b%b expected %b", k,
                             m1_if.waitrequest, m0_if.waitrequest, want_wait);
                end
            end
            commit_cycle();
        end
    endtask

    task automatic test_byte_lanes();
        logic [DW-1:0] want;
        apply_reset();
        want = init_word(7'h7F);
        want[7:0] = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            idle_all();
            if (k == 0) set_req(1, 1'b0, 1'b1, 7'h7F, 4'h1, 32'h0000_00AA, 1'b0);
            if (k == 1) set_req(1, 1'b1, 1'b0, 7'h7F, 4'hF, '0, 1'b0);
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL byte_lanes cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            if (k == 2) begin
                n_cmp++;
                if (m1_if.readdatavalid !== 1'b1 || m1_if.readdata !== want) begin
                    n_bad++;
                    $display("[TB] FAIL byte_lanes_data: got v=%b d=%h expected v=1 d=%h",
                             m1_if.readdatavalid, m1_if.readdata, want);
                end
            end
            commit_cycle();
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_req(0, 1'b1, 1'b0, 7'h22, 4'hF, '0, 1'b0);
        eval_cycle();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("[TB] FAIL midread_issue: got %h expected %h", obs_vec, exp_vec);
        end
        commit_cycle();
        idle_all();
        reset_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) reset_n = 1'b1;
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL midread cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            n_cmp++;
            if (m0_if.readdatavalid !== 1'b0 || ram_chipselect !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL midread_drop cyc%0d: got v=%b cs=%b expected v=0 cs=0", k,
                         m0_if.readdatavalid, ram_chipselect);
            end
            commit_cycle();
        end
    endtask

    task automatic test_random();
        int op;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++) begin
                op = int'($urandom_range(0, 3));
                set_req(m, op[0], op[1], AW'($urandom_range(0, 15) + (k % 8) * 16),
                        BW'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
            end
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL random cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            commit_cycle();
        end
        idle_all();
        eval_cycle();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("[TB] FAIL random_drain: got %h expected %h", obs_vec, exp_vec);
        end
        commit_cycle();
    endtask

`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] want_wait;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            set_req(0, 1'b1, 1'b0, 7'h30, 4'hF, '0, 1'b1);
            set_req(1, 1'b1, 1'b0, 7'h31, 4'hF, '0, 1'b0);
            eval_cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++;
                $display("[TB] FAIL lock cyc%0d: got %h expected %h", k, obs_vec, exp_vec);
            end
            want_wait = (k == 9) ? 2'b01 : 2'b10;
            n_cmp++;
            if ({m1_if.waitrequest, m0_if.waitrequest} !== want_wait) begin
                n_bad++;
                $display("[TB] FAIL lock_order cyc%0d: got %b%b expected %b", k,
                         m1_if.waitrequest, m0_if.waitrequest, want_wait);
            end
            commit_cycle();
        end
        idle_all();
        eval_cycle();
        n_cmp++;
        if (obs_vec !== exp_vec) begin
            n_bad++;
            $display("[TB] FAIL lock_drain: got %h expected %h", obs_vec, exp_vec);
        end
        commit_cycle();
    endtask
`endif

    // Run every scenario in order and report one summary line.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = init_word(i);
        idle_all();
        model_reset();
        exp_grant = -1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_contention();
        test_byte_lanes();
        test_reset_mid_read();
        test_random();
`ifdef NIOS_SYSTEM_RAM_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nios_system_ram_arbiter.md
NIOS_SYSTEM_RAM_ARBITER -- requirements
Module: nios_system_ram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 7, word address width; DATA_W, default 32, data width; BE_W, default 4, byteenable width (DATA_W/8).
REQ-002 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have mN_address  input  ADDR_W  requester N word address (N = 0, 1; applies to REQ-004..REQ-012).
REQ-005 SHALL have mN_byteenable  input  BE_W  requester N byte lanes.
REQ-006 SHALL have mN_read and mN_write  input  1 each  requester N read / write request.
REQ-007 SHALL have mN_writedata  input  DATA_W  requester N write data.
REQ-008 SHALL have mN_lock  input  1  requester N holds grant (used only with REQ-031).
REQ-009 SHALL have mN_waitrequest  output  1  request not accepted this cycle.
REQ-010 SHALL have mN_readdata  output  DATA_W  read data to requester N.
REQ-011 SHALL have mN_readdatavalid  output  1  mN_readdata valid this cycle.
REQ-012 SHALL have ram_address (ADDR_W), ram_byteenable (BE_W), ram_chipselect (1), ram_write (1), ram_writedata (DATA_W)  outputs  to RAM port s1.
REQ-013 SHALL have ram_readdata  input  DATA_W  RAM port s1 q, valid 1 cycle after the address is presented.

Function
REQ-014 SHALL define reqN = mN_read | mN_write; mN_write with mN_read SHALL be treated as a write, read ignored.
REQ-015 SHALL decide grant combinationally each cycle: one requester -> it wins; both -> requester not in last_grant wins; none -> no grant.
REQ-016 SHALL update last_grant to the granted index on each granted cycle and hold it otherwise.
REQ-017 SHALL drive mN_waitrequest = reqN & ~grantN; a granted access is accepted in the same cycle (zero wait states when uncontested).
REQ-018 SHALL drive ram_chipselect = any grant; ram_address, ram_byteenable, ram_writedata and ram_write from the granted requester; ram_write = 0 for reads.
REQ-019 SHALL, with no grant, drive ram_chipselect = 0, ram_write = 0 and the other RAM outputs to 0.
REQ-020 SHALL register rd_pending and rd_owner on a granted read; the next cycle SHALL assert m<rd_owner>_readdatavalid for exactly 1 cycle with mN_readdata = ram_readdata.
REQ-021 SHALL hold mN_readdata = 0 when mN_readdatavalid = 0.
REQ-022 SHALL sustain back-to-back reads (one per cycle) with fixed read latency 1 and in-order responses.
REQ-023 SHALL support a write and a read to the same address in consecutive cycles; the read returns the new data.
REQ-024 SHALL keep bandwidth fair: under continuous contention grants alternate 0,1,0,1...
REQ-025 SHALL never grant both requesters in one cycle and never issue a RAM write without a grant.

Reset
REQ-026 SHALL, while reset_n = 0, force no grant: ram_chipselect = 0, ram_write = 0, mN_waitrequest = reqN.
REQ-027 SHALL reset last_grant = 1 (first tie goes to m0), rd_pending = 0, rd_owner = 0, lock_cnt = 0, mN_readdatavalid = 0.
REQ-028 SHALL discard a read in flight when reset asserts mid-operation; no readdatavalid follows reset release.
REQ-029 SHALL accept requests on the first rising edge after reset_n deasserts.

Configuration
REQ-030 SHALL honour macro NIOS_SYSTEM_RAM_ARB_LOCK_EN.
REQ-031 SHALL, when defined, give the last granted requester priority over round-robin while it asserts mN_lock with reqN; lock_cnt (3 bits) counts consecutive locked grants; after 8 the lock SHALL be ignored for one arbitration, and lock_cnt SHALL clear on an unlocked grant or a grant change.
REQ-032 SHALL, when undefined, ignore mN_lock, omit lock_cnt and arbitrate per REQ-015 only.

Verification
REQ-033 SHALL cover: after reset, m0 writes 0xDEADBEEF, be=0xF, addr 0x05; m0 then reads 0x05 -> m0_waitrequest 0 both cycles, readdatavalid 1 cycle later with 0xDEADBEEF.
REQ-034 SHALL cover: m0 and m1 read addr 0x10/0x11 every cycle for 6 cycles -> grants 0,1,0,1,0,1; each waitrequest asserted on alternate cycles; responses in order.
REQ-035 SHALL cover: m1 writes 0x000000AA with be=0x1 to 0x7F (wrap-top address), then reads it -> 0x000000AA in byte 0; upper bytes unchanged.
REQ-036 SHALL cover: reset_n pulsed low the cycle after m0 issues a read -> no m0_readdatavalid; ram_chipselect 0 during reset.
REQ-037 SHALL cover, with NIOS_SYSTEM_RAM_ARB_LOCK_EN: m0 locked, both requesting for 10 cycles -> m0 granted cycles 1-8, m1 cycle 9, m0 cycle 10.
